dma_xfer_ctrl: RTL and testbench
================================

// Module: dma_xfer_ctrl
// PURPOSE
//  Single-channel DMA transfer sequencer that drives the DMA memory bus (wr_en/rd_en/addr/wdata/rdata).
//  Copies LEN 32-bit words from a source region to a destination region as read-then-write word pairs.
//  Sits between the config/register side (start/src/dst/len) and the memory bus seen by dma_intf drivers/monitors.
// PARAMETERS
//  ADDR_INC  4   byte increment applied to src/dst address per word (32-bit wrap)
//  LEN_W     16  width of len and cnt
//  RD_LAT    1   cycles from rd_en cycle to valid rdata; legal range 1..15
// PORTS
//  clk       in   1       single clock, all logic on posedge
//  rst_n     in   1       asynchronous active-low reset
//  start     in   1       transfer request; honoured only in IDLE
//  src_addr  in   32      source byte address, latched on accepted start
//  dst_addr  in   32      destination byte address, latched on accepted start
//  len       in   LEN_W   word count, latched on accepted start
//  busy      out  1       high in RD/WAIT/WR
//  done      out  1       one-cycle pulse on normal completion
//  cnt       out  LEN_W   words written since last accepted start
//  rd_en     out  1       bus read strobe
//  wr_en     out  1       bus write strobe
//  addr      out  32      bus address
//  wdata     out  32      bus write data
//  rdata     in   32      bus read data, valid RD_LAT cycles after rd_en cycle
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy,done,rd_en,wr_en=0; addr,wdata=0; cnt=0; internal regs 0.
//  - All outputs registered; rd_en and wr_en never high in the same cycle.
//  - States: IDLE, RD, WAIT, WR.
//  - IDLE: start=1 latches src/dst/len, clears cnt. len!=0 -> RD; len==0 -> stay IDLE, done=1 next cycle, no bus activity.
//  - RD (1 cycle): rd_en=1, addr=src_cur -> WAIT; lat counter loaded with RD_LAT.
//  - WAIT: counts down; rdata captured at the edge ending cycle t+RD_LAT (t = rd_en cycle) -> WR.
//  - WR (1 cycle): wr_en=1, addr=dst_cur, wdata=captured word. At its end: src_cur+=ADDR_INC, dst_cur+=ADDR_INC, cnt+=1, remaining-=1.
//  - After WR: remaining==0 -> IDLE with done=1 for exactly the first IDLE cycle; else -> RD.
//  - Per-word cost RD_LAT+2 cycles; LEN words = LEN*(RD_LAT+2) cycles, start edge to done.
//  - Idle bus: rd_en=wr_en=0; addr/wdata hold last driven values.
//  - start while busy: ignored, no latch change. start during the done cycle: accepted (state is IDLE).
//  - Address arithmetic modulo 2^32: 0xFFFF_FFFC+4 -> 0x0000_0000, no error.
//  - len = 2^LEN_W-1 supported; cnt never wraps within a transfer.
//  - Reset mid-transfer: immediate abandon; no further bus strobes, cnt=0, no done pulse.
// CONFIGURATION
//  - Macro DMA_XFER_CTRL_ABORT_EN defined: adds ports abort (in,1) and aborted (out,1, one-cycle pulse).
//    abort sampled high in RD/WAIT/WR sets a sticky flag; the in-flight word completes its WR, then
//    -> IDLE with aborted=1, done=0; cnt holds words written. abort in IDLE ignored; flag cleared on start.
//  - Macro not defined: abort/aborted ports absent; every accepted transfer runs to done.
// TESTING
//  - RD_LAT=1, src=0x100 dst=0x200 len=3, mem[0x100..0x108]=A,B,C -> writes A@0x200,B@0x204,C@0x208; done 9 cycles after start; cnt=3.
//  - len=0 start -> done=1 next cycle, rd_en/wr_en never high, cnt=0, busy stays 0.
//  - start pulsed again during word 2 of a len=4 transfer -> ignored; exactly 4 writes, dst sequence unchanged.
//  - src=0xFFFF_FFFC dst=0x0000_0FFC len=2 -> reads at 0xFFFF_FFFC,0x0; writes at 0xFFC,0x1000.
//  - RD_LAT=3, len=2 -> rd_en to wr_en spacing 4 cycles; done 10 cycles after start; wdata equals rdata sampled at t+3.
//  - rst_n low during WAIT of word 2 -> all outputs 0 same cycle; no write of word 2; new start after release runs clean.
//  - ABORT_EN: abort during word 2 WAIT of len=5 -> word 2 written, aborted pulse, done=0, cnt=2.

Source files
------------

// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer: copies len 32-bit words src->dst as read/write pairs on a simple memory bus.
// Optional abort support (abort/aborted ports) is compiled in when DMA_XFER_CTRL_ABORT_EN is defined.
module dma_xfer_ctrl #(
  parameter int unsigned ADDR_INC = 4,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] cnt,
  output logic             rd_en,
  output logic             wr_en,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata
`ifdef DMA_XFER_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam logic [31:0]      INC      = 32'(ADDR_INC);
  localparam logic [3:0]       LAT_INIT = 4'(RD_LAT);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lat_q, lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             abort_hit;

`ifdef DMA_XFER_CTRL_ABORT_EN
  logic abort_flag_q, abort_flag_d;
  logic aborted_q, aborted_d;

  // A request seen in any busy cycle, including the final WR, ends the transfer after that WR.
  assign abort_hit = abort_flag_q | abort;
  assign aborted   = aborted_q;

  always_comb begin
    abort_flag_d = abort_flag_q;
    aborted_d    = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) abort_flag_d = 1'b0;
    end else if (abort) begin
      abort_flag_d = 1'b1;
    end
    if (state_q == S_WR && abort_hit) begin
      abort_flag_d = 1'b0;
      aborted_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_flag_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      abort_flag_q <= abort_flag_d;
      aborted_q    <= aborted_d;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  // Bus outputs are registered, so they are computed from the state being entered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = len;
          cnt_d = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RD;
            rd_en_d = 1'b1;
            addr_d  = src_addr;
          end
        end
      end
      S_RD: begin
        state_d = S_WAIT;
        lat_d   = LAT_INIT;
      end
      S_WAIT: begin
        if (lat_q == 4'd1) begin
          state_d = S_WR;
          wr_en_d = 1'b1;
          addr_d  = dst_q;
          wdata_d = rdata;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_WR: begin
        src_d = src_q + INC;
        dst_d = dst_q + INC;
        cnt_d = cnt_q + ONE;
        rem_d = rem_q - ONE;
        if (abort_hit) begin
          state_d = S_IDLE;
        end else if (rem_q == ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
          rd_en_d = 1'b1;
          addr_d  = src_q + INC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign cnt   = cnt_q;
  assign rd_en = rd_en_q;
  assign wr_en = wr_en_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Bench for dma_xfer_ctrl: two instances (RD_LAT 1 and 3) against a latency-accurate memory responder
// and a transfer-level reference model of expected reads, writes and timing.
module tb_dma_xfer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_in;
  logic        start_a   [2];
  logic        busy_a    [2];
  logic        done_a    [2];
  logic [15:0] cnt_a     [2];
  logic        rd_en_a   [2];
  logic        wr_en_a   [2];
  logic [31:0] addr_a    [2];
  logic [31:0] wdata_a   [2];
  logic [31:0] rdata_a   [2];
`ifdef DMA_XFER_CTRL_ABORT_EN
  logic        abort_a   [2];
  logic        aborted_a [2];
  int          aborted_cyc_q[$];
`endif

  dma_xfer_ctrl #(.ADDR_INC(4), .LEN_W(16), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len_in), .busy(busy_a[0]), .done(done_a[0]), .cnt(cnt_a[0]), .rd_en(rd_en_a[0]),
    .wr_en(wr_en_a[0]), .addr(addr_a[0]), .wdata(wdata_a[0]), .rdata(rdata_a[0])
`ifdef DMA_XFER_CTRL_ABORT_EN
    , .abort(abort_a[0]), .aborted(aborted_a[0])
`endif
  );

  dma_xfer_ctrl #(.ADDR_INC(4), .LEN_W(16), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len_in), .busy(busy_a[1]), .done(done_a[1]), .cnt(cnt_a[1]), .rd_en(rd_en_a[1]),
    .wr_en(wr_en_a[1]), .addr(addr_a[1]), .wdata(wdata_a[1]), .rdata(rdata_a[1])
`ifdef DMA_XFER_CTRL_ABORT_EN
    , .abort(abort_a[1]), .aborted(aborted_a[1])
`endif
  );

  // Scoreboard state
  int          n_chk, n_pass, n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_r_q[$];
  logic [31:0] rd_q[$], wr_a_q[$], wr_d_q[$];
  int          rd_cyc_q[$], wr_cyc_q[$], done_cyc_q[$];
  int          busy_cnt, both_hi, cyc, start_cyc, sel, mon_lat;
  logic [31:0] seed;
  logic        pv [2][16];
  logic [31:0] pa [2][16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ seed) * 32'h9E37_79B1) + 32'h7F4A_7C15;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    rd_q.delete(); rd_cyc_q.delete();
    wr_a_q.delete(); wr_d_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete();
`ifdef DMA_XFER_CTRL_ABORT_EN
    aborted_cyc_q.delete();
`endif
    busy_cnt  = 0;
    both_hi   = 0;
    start_cyc = -1;
  endtask

  // Memory responder and bus monitor; everything is observed 1 time unit after the clock edge.
  always @(posedge clk) begin
    cyc++;
    if (start_a[sel] && start_cyc < 0) start_cyc = cyc;
    #1;
    for (int g = 0; g < 2; g++) begin
      for (int i = 15; i > 0; i--) begin
        pv[g][i] = pv[g][i-1];
        pa[g][i] = pa[g][i-1];
      end
      pv[g][0] = rd_en_a[g];
      pa[g][0] = addr_a[g];
      mon_lat = (g == 0) ? 1 : 3;
      rdata_a[g] = pv[g][mon_lat] ? mem_word(pa[g][mon_lat]) : $urandom;
      if (rd_en_a[g] && wr_en_a[g]) both_hi++;
    end
    if (rd_en_a[sel]) begin
      rd_q.push_back(addr_a[sel]);
      rd_cyc_q.push_back(cyc);
    end
    if (wr_en_a[sel]) begin
      wr_a_q.push_back(addr_a[sel]);
      wr_d_q.push_back(wdata_a[sel]);
      wr_cyc_q.push_back(cyc);
    end
    if (done_a[sel]) done_cyc_q.push_back(cyc);
    if (busy_a[sel]) busy_cnt++;
`ifdef DMA_XFER_CTRL_ABORT_EN
    if (aborted_a[sel]) aborted_cyc_q.push_back(cyc);
`endif
  end

  // One transfer; restart_at>0 pulses start again that many cycles after the first busy cycle.
  task automatic run_xfer(input int inst, input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] n, input int restart_at);
    int lat, per;
    lat = (inst == 0) ? 1 : 3;
    per = lat + 2;
    clear_obs();
    sel  = inst;
    seed = $urandom;
    exp_q.delete(); exp_a_q.delete(); exp_r_q.delete();
    for (int k = 0; k < int'(n); k++) begin
      exp_r_q.push_back(src + 32'(k) * 32'd4);
      exp_a_q.push_back(dst + 32'(k) * 32'd4);
      exp_q.push_back(mem_word(src + 32'(k) * 32'd4));
    end
    @(negedge clk);
    src_addr = src; dst_addr = dst; len_in = n; start_a[inst] = 1'b1;
    @(negedge clk);
    start_a[inst] = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; len_in = 16'($urandom);
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge clk);
      start_a[inst] = 1'b1;
      @(negedge clk);
      start_a[inst] = 1'b0;
    end
    for (int i = 0; i < int'(n) * per + 20 && done_cyc_q.size() == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cyc_q.size(), 1);
    chk("done_latency", (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1, int'(n) * per);
    chk("cnt_final", cnt_a[inst], n);
    chk("busy_cycles", busy_cnt, int'(n) * per);
    chk("busy_after", busy_a[inst], 1'b0);
    chk("rd_wr_exclusive", both_hi, 0);
    chk("rd_count", rd_q.size(), exp_r_q.size());
    chk("wr_count", wr_a_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < rd_q.size()) begin
        chk($sformatf("rd_addr[%0d]", k), rd_q[k], exp_r_q[k]);
        chk($sformatf("rd_cycle[%0d]", k), rd_cyc_q[k] - start_cyc, k * per);
      end
      if (k < wr_a_q.size()) begin
        chk($sformatf("wr_addr[%0d]", k), wr_a_q[k], exp_a_q[k]);
        chk($sformatf("wr_data[%0d]", k), wr_d_q[k], exp_q[k]);
        chk($sformatf("wr_cycle[%0d]", k), wr_cyc_q[k] - start_cyc, k * per + lat + 1);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0; sel = 0; seed = '0;
    rst_n = 1'b0; src_addr = '0; dst_addr = '0; len_in = '0;
    for (int g = 0; g < 2; g++) begin
      start_a[g] = 1'b0;
      rdata_a[g] = '0;
`ifdef DMA_XFER_CTRL_ABORT_EN
      abort_a[g] = 1'b0;
`endif
      for (int i = 0; i < 16; i++) begin
        pv[g][i] = 1'b0;
        pa[g][i] = '0;
      end
    end
    clear_obs();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", busy_a[g], 1'b0);
      chk("rst_done", done_a[g], 1'b0);
      chk("rst_rd_en", rd_en_a[g], 1'b0);
      chk("rst_wr_en", wr_en_a[g], 1'b0);
      chk("rst_addr", addr_a[g], 32'h0);
      chk("rst_wdata", wdata_a[g], 32'h0);
      chk("rst_cnt", cnt_a[g], 16'h0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(0, 32'h0000_0100, 32'h0000_0200, 16'd3, 0);
    run_xfer(0, 32'h0000_0A00, 32'h0000_0B00, 16'd0, 0);
    run_xfer(0, 32'h0000_1000, 32'h0000_2000, 16'd4, 4);
    run_xfer(0, 32'hFFFF_FFFC, 32'h0000_0FFC, 16'd2, 0);
    run_xfer(1, 32'h0000_0500, 32'h0000_0600, 16'd2, 0);
    run_xfer(1, 32'h0000_0700, 32'h0000_0800, 16'd0, 0);

    // Reset asserted mid-cycle during the WAIT of word 2
    clear_obs();
    sel = 0;
    @(negedge clk);
    src_addr = 32'h0000_3000; dst_addr = 32'h0000_4000; len_in = 16'd3; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    for (int i = 0; i < 20 && cyc < start_cyc + 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_a[0], 1'b0);
    chk("midrst_rd_en", rd_en_a[0], 1'b0);
    chk("midrst_wr_en", wr_en_a[0], 1'b0);
    chk("midrst_addr", addr_a[0], 32'h0);
    chk("midrst_wdata", wdata_a[0], 32'h0);
    chk("midrst_cnt", cnt_a[0], 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_wr_count", wr_a_q.size(), 1);
    chk("midrst_no_done", done_cyc_q.size(), 0);
    run_xfer(0, 32'h0000_5000, 32'h0000_6000, 16'd2, 0);

    for (int t = 0; t < 6; t++) begin
      run_xfer(int'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               16'($urandom_range(1, 6)), 0);
    end

`ifdef DMA_XFER_CTRL_ABORT_EN
    clear_obs();
    sel  = 0;
    seed = $urandom;
    @(negedge clk);
    src_addr = 32'h0000_7000; dst_addr = 32'h0000_8000; len_in = 16'd5; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (4) @(negedge clk);
    abort_a[0] = 1'b1;
    @(negedge clk);
    abort_a[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_wr_count", wr_a_q.size(), 2);
    chk("abort_wr1_addr", (wr_a_q.size() > 1) ? wr_a_q[1] : 32'h0, 32'h0000_8004);
    chk("abort_wr1_data", (wr_d_q.size() > 1) ? wr_d_q[1] : 32'h0, mem_word(32'h0000_7004));
    chk("abort_no_done", done_cyc_q.size(), 0);
    chk("abort_pulses", aborted_cyc_q.size(), 1);
    chk("abort_when", (aborted_cyc_q.size() > 0) ? aborted_cyc_q[0] - start_cyc : -1, 6);
    chk("abort_cnt", cnt_a[0], 16'd2);
    chk("abort_busy", busy_a[0], 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
